// File: rtl/vc_input_buffer_pkg.sv
// Shared types and constants for the per-port virtual-channel input buffer.
`include "global.vh"

package vc_input_buffer_pkg;

    localparam int NUM_VC = 4;
    localparam int TIME_W = `TIME_WIDTH;
    localparam int VC_W   = `VC_INDEX_WIDTH;
    localparam int DATA_W = `DATA_WIDTH;

    typedef struct packed {
        logic [TIME_W-1:0] ts;
        logic [DATA_W-1:0] data;
    } flit_t;

    // One-hot select of a VC, all zeros when the request is idle.
    function automatic logic [NUM_VC-1:0] vc_onehot(input logic en, input logic [VC_W-1:0] vc);
        vc_onehot = '0;
        if (en) begin
            vc_onehot[vc] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/global.vh
// Project-wide flit field widths shared by the router blocks.
`ifndef GLOBAL_VH
`define GLOBAL_VH

`define TIME_WIDTH      8
`define VC_INDEX_WIDTH  2
`define DATA_WIDTH      16

`endif

// File: rtl/vcFifo.sv
// Single-VC flit FIFO: DEPTH slots, head visible combinationally after each edge.
module vcFifo
    import vc_input_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  flit_t             push_flit,
    output logic [TIME_W-1:0] head_time,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    flit_t            mem [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage is left unreset; stale slots are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail_reg] <= push_flit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // An empty VC reports the latest possible time so it never wins oldest-first arbitration.
    assign head_time = empty ? '1 : mem[head_reg].ts;
    assign head_data = mem[head_reg].data;
    assign count     = count_reg;

endmodule

// File: rtl/vc_input_buffer.sv
// Input port buffer: one FIFO per VC, VC decode, payload select, credit return, overflow flag.
module vc_input_buffer
    import vc_input_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [VC_W-1:0]   in_vc,
    input  logic [TIME_W-1:0] in_time,
    input  logic [DATA_W-1:0] in_data,
    input  logic              deq_valid,
    input  logic [VC_W-1:0]   deq_vc,
    output logic [TIME_W-1:0] time_out_0,
    output logic [TIME_W-1:0] time_out_1,
    output logic [TIME_W-1:0] time_out_2,
    output logic [TIME_W-1:0] time_out_3,
    output logic [DATA_W-1:0] data_out,
    output logic [NUM_VC-1:0] empty,
    output logic [NUM_VC-1:0] full,
    output logic [NUM_VC-1:0] credit_out,
    output logic              overflow_err
);

    logic [NUM_VC-1:0] push_req;
    logic [NUM_VC-1:0] pop_req;
    logic [NUM_VC-1:0] pop_ok;
    logic [NUM_VC-1:0] vc_empty;
    logic [NUM_VC-1:0] vc_full;
    logic [NUM_VC-1:0] credit_reg;
    logic              overflow_reg;
    logic [TIME_W-1:0] head_time [NUM_VC];
    logic [DATA_W-1:0] head_data [NUM_VC];
    logic [CNT_W-1:0]  vc_count  [NUM_VC];
    flit_t             in_flit;

    assign in_flit  = '{ts: in_time, data: in_data};
    assign push_req = vc_onehot(in_valid, in_vc);
    assign pop_req  = vc_onehot(deq_valid, deq_vc);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
            vcFifo #(
                .DEPTH(DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (push_req[gi]),
                .pop       (pop_req[gi]),
                .push_flit (in_flit),
                .head_time (head_time[gi]),
                .head_data (head_data[gi]),
                .empty     (vc_empty[gi]),
                .full      (vc_full[gi]),
                .count     (vc_count[gi])
            );
            // A pop only returns a credit when the VC actually held a flit.
            assign pop_ok[gi] = pop_req[gi] && (vc_count[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            credit_reg <= pop_ok;
            if (in_valid && vc_full[in_vc]) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign time_out_0   = head_time[0];
    assign time_out_1   = head_time[1];
    assign time_out_2   = head_time[2];
    assign time_out_3   = head_time[3];
    assign data_out     = head_data[deq_vc];
    assign empty        = vc_empty;
    assign full         = vc_full;
    assign credit_out   = credit_reg;
    assign overflow_err = overflow_reg;

endmodule
